memory_stage: RTL
=================

# memory_stage

Pipeline stage between execute and `writeback`. Accepts one instruction per cycle from execute, performs the data-memory access for `OPC_LOAD`/`OPC_STORE` over a req/ready handshake, and presents a registered `InstructionDetails` + 32-bit data pair to `writeback`. Non-memory ops pass through with one cycle of latency. Memory ops stall upstream until the access completes or times out.

## Interface
- `TIMEOUT_CYCLES`, 15: max cycles `mem_req` may stay high without `mem_ready` before the access is aborted (1..255).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `details_in`  in  `types::InstructionDetails`  instruction from execute; `is_valid` qualifies.
- `alu_result`  in  32  execute result; the address for load/store, the data otherwise.
- `store_data`  in  32  value to store (rs2), used only for `OPC_STORE`.
- `stall`  out  1  upstream must hold `details_in`/`alu_result`/`store_data` stable.
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  1 = store, 0 = load; valid while `mem_req`.
- `mem_addr`  out  20  word address = `alu_result[19:0]`, latched at accept.
- `mem_wdata`  out  32  latched `store_data`.
- `mem_ready`  in  1  memory completes the request this cycle.
- `mem_rdata`  in  32  load data; valid when `mem_ready`.
- `details_out`  out  `types::InstructionDetails`  to `writeback`.
- `data_out`  out  32  to `writeback`.
- `mem_fault`  out  1  one-cycle pulse: access timed out.

## Operation
- States: `IDLE`, `ACCESS`.
- `IDLE`: `stall`=0. At each edge, sample inputs:
  - invalid: `details_out.is_valid`←0.
  - valid non-memory op: `details_out`←`details_in`, `data_out`←`alu_result`. Stay `IDLE`.
  - valid `OPC_LOAD`/`OPC_STORE`: latch details, address, store data, and set `mem_we`. `details_out.is_valid`←0. Go to `ACCESS`. Clear the timer.
- `ACCESS`: `stall`=1, `mem_req`=1, `details_out.is_valid`=0 (bubble). Timer increments each cycle `mem_ready`=0.
  - `mem_ready`=1 at an edge: `details_out`←latched details. `data_out`←`mem_rdata` for a load, or the latched address zero-extended for a store (`writeback` ignores it). Go to `IDLE`.
  - Timer reaches `TIMEOUT_CYCLES` with `mem_ready`=0: drop the instruction (`details_out.is_valid`←0), pulse `mem_fault` for one cycle, go to `IDLE`.
  - `mem_ready` in the same cycle as timeout: completion wins and there is no fault.
- `mem_ready` while `mem_req`=0 is ignored.
- No input is accepted in `ACCESS`. The instruction held by upstream is accepted in the first `IDLE` cycle.
- `mem_addr`/`mem_we`/`mem_wdata` stay constant for the whole `ACCESS` period.

## Timing
- Reset (synchronous, takes effect at the edge): state `IDLE`, `stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `details_out`='0 (`is_valid`=0), `data_out`=0, `mem_fault`=0, timer 0.
- Reset during `ACCESS` abandons the access. `mem_req` is low from the reset edge onward and no fault is raised.
- Non-memory latency: 1 cycle (input at edge N, output valid after N).
- Memory latency: accept at edge N. `mem_req` is high after N. Completion at the first edge with `mem_ready`=1, giving a minimum of 2 cycles. Output is valid for exactly one cycle after completion.
- Throughput: 1 instr/cycle for non-memory ops. Memory ops occupy ≥2 cycles, with one bubble cycle at the output per `ACCESS` cycle.
- `stall` is a Moore output (state only), so upstream has no combinational path from `mem_ready`.
- Timer is 8 bits. With `mem_req` high for `TIMEOUT_CYCLES` cycles, abort happens at the edge ending the `TIMEOUT_CYCLES`-th cycle.

## Structure
- Add to package `types`: `OPC_LOAD` (if absent, beside `OPC_STORE`), and `typedef enum logic {MEM_IDLE, MEM_ACCESS} MemState`.
- One sub-module, `mem_timer`: a saturating 8-bit counter with `clear` and `en` inputs and an `expired` output (count == limit). It is parameterised by `TIMEOUT_CYCLES`.
- All outputs to `writeback` and memory are registered.

## Test plan
- ALU op: valid `details_in` (non-mem), `alu_result`=0x1234 → next cycle `details_out.is_valid`=1, `data_out`=0x1234, `stall`=0, `mem_req`=0.
- Load, `alu_result`=0x00040, `mem_ready` on the 3rd `ACCESS` cycle with `mem_rdata`=0xDEADBEEF → `mem_addr`=0x00040 and `mem_we`=0 for 3 cycles, `stall`=1 for 3 cycles, then `data_out`=0xDEADBEEF with `is_valid`=1 for 1 cycle.
- Store, `store_data`=0xCAFEF00D, `mem_ready` on the 1st `ACCESS` cycle → `mem_we`=1, `mem_wdata`=0xCAFEF00D, store `details_out` valid 2 cycles after accept.
- Timeout with `TIMEOUT_CYCLES`=4 and `mem_ready` held 0 → `mem_req` high 4 cycles, then `mem_fault` pulses once, no valid output, and the held next ALU op is accepted the following cycle.
- `rst` asserted on the 2nd `ACCESS` cycle → after the edge `mem_req`=0, `stall`=0, `details_out.is_valid`=0, `mem_fault`=0. A late `mem_ready` is ignored.
- Load then ALU op back-to-back, upstream honouring `stall` → load result, then the ALU result the cycle after, with no loss or duplication.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// types: shared pipeline types and memory-stage helpers
package types;
    typedef enum logic [2:0] {OPC_NOP, OPC_ALU, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JUMP} Opcode;
    typedef struct packed {
        logic       is_valid;
        Opcode      opcode;
        logic [4:0] rd;
    } InstructionDetails;
    typedef enum logic {MEM_IDLE, MEM_ACCESS} MemState;
    function automatic logic is_mem_op(input Opcode opc);
        return opc == OPC_LOAD || opc == OPC_STORE;
    endfunction
endpackage

// File: rtl/memory_stage_timer.sv
// mem_timer: saturating 8-bit access timer; expired marks the final permitted access cycle
module mem_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] count_q, count_d;
    always_comb count_d = clear ? 8'd0 : (en && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    always_ff @(posedge clk) count_q <= rst ? 8'd0 : count_d;
    // count starts at 0 in the first access cycle, so LIMIT is reached during cycle TIMEOUT_CYCLES
    assign expired = count_q == LIMIT;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: execute-to-writeback stage performing load/store over a req/ready handshake
module memory_stage
    import types::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  InstructionDetails details_in,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [19:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output InstructionDetails details_out,
    output logic [31:0]       data_out,
    output logic              mem_fault
);
    MemState           state_q, state_d;
    InstructionDetails details_q, details_d, held_q, held_d;
    logic [31:0]       data_q, data_d, wdata_q, wdata_d;
    logic [19:0]       addr_q, addr_d;
    logic              we_q, we_d, fault_q, fault_d;
    logic              timer_clear, timer_en, expired;

    mem_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk), .rst(rst), .clear(timer_clear), .en(timer_en), .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        details_d = details_q;
        details_d.is_valid = 1'b0;
        held_d = held_q;
        data_d = data_q;
        addr_d = addr_q;
        we_d = we_q;
        wdata_d = wdata_q;
        fault_d = 1'b0;
        timer_clear = 1'b0;
        timer_en = 1'b0;
        if (state_q == MEM_IDLE) begin
            if (details_in.is_valid && is_mem_op(details_in.opcode)) begin
                held_d = details_in;
                addr_d = alu_result[19:0];
                wdata_d = store_data;
                we_d = details_in.opcode == OPC_STORE;
                timer_clear = 1'b1;
                state_d = MEM_ACCESS;
            end else if (details_in.is_valid) begin
                details_d = details_in;
                data_d = alu_result;
            end
        end else if (mem_ready) begin
            details_d = held_q;
            data_d = we_q ? {12'd0, addr_q} : mem_rdata;
            state_d = MEM_IDLE;
        end else if (expired) begin
            fault_d = 1'b1;
            state_d = MEM_IDLE;
        end else begin
            timer_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            details_q <= '0;
            held_q <= '0;
            data_q <= '0;
            addr_q <= '0;
            we_q <= 1'b0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            details_q <= details_d;
            held_q <= held_d;
            data_q <= data_d;
            addr_q <= addr_d;
            we_q <= we_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

    assign stall = state_q == MEM_ACCESS;
    assign mem_req = state_q == MEM_ACCESS;
    assign mem_we = we_q;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign details_out = details_q;
    assign data_out = data_q;
    assign mem_fault = fault_q;
endmodule
